// File: rtl/adc_spi_responder_pkg.sv
// Shared types and constants for the ADC SPI responder.
// No logic; constants only.
// No flow control.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam int DEF_DATA_W     = 12;
  localparam int DEF_LEAD_ZEROS = 4;
  localparam int FRAME_BITS     = DEF_LEAD_ZEROS + DEF_DATA_W;

  // Channel address rides on DIN rising edges 2..4 (0-based), MSB first
  localparam int ADDR_FIRST_EDGE = 2;
  localparam int ADDR_BITS       = 3;

  localparam int          RCNT_W   = 5;
  localparam logic [4:0]  RCNT_MAX = 5'd31;

endpackage

// File: rtl/adc_spi_responder_sync_edge.sv
// Synchronizer chain with edge detection on the synchronized level.
// Latency: STAGES CLK to level, edge pulses in the same cycle as the level change.
// No flow control; edge pulses are one CLK wide.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain and remember the last synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Serial ADC emulator: shifts 16-bit frames out on ADC_DOUT and decodes the channel address on ADC_DIN.
// Latency: pin CS_N/SCLK edge to DOUT or status pulse 3 CLK; chan_sel 4 CLK after CS_N rise.
// Backpressure: sample_ready low while the single holding register is full; an empty hold at frame start replays last_sample.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              ADC_CS_N,
  input  logic              ADC_SCLK,
  input  logic              ADC_DIN,
  output logic              ADC_DOUT,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [2:0]        chan_sel,
  output logic              frame_done,
  output logic              frame_err,
  output logic              underrun
);

  localparam int FRAME_LEN = LEAD_ZEROS + DATA_W;

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;

  // CS_N chain resets low so a frame already in progress at reset release is never mistaken for a new one
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs_sync (
    .clk     (CLK),
    .rst_n   (RSTB),
    .d_i     (ADC_CS_N),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk     (CLK),
    .rst_n   (RSTB),
    .d_i     (ADC_SCLK),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  logic [SYNC_STAGES-1:0] din_q;
  logic                   din_s;

  // DIN delayed by the same depth as SCLK so a rising-edge pulse lines up with the bit it clocks
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) din_q <= '0;
    else       din_q <= (din_q << 1) | SYNC_STAGES'(ADC_DIN);
  end
  assign din_s = din_q[SYNC_STAGES-1];

  state_t                  state_q;
  logic [FRAME_LEN-1:0]    shift_q;
  logic                    dout_q;
  logic [RCNT_W-1:0]       rcnt_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [2:0]              chan_sel_q;
  logic                    frame_done_q, frame_err_q, underrun_q;
  logic                    full_q;
  logic [DATA_W-1:0]       hold_q, last_q;

  logic                    hs, frame_start;
  logic [FRAME_LEN-1:0]    frame_word;

  assign hs          = sample_valid & ~full_q;
  assign frame_start = (state_q == IDLE) & cs_fall;
  assign frame_word  = {{LEAD_ZEROS{1'b0}}, (full_q ? hold_q : last_q)};

  // Holding register: a frame start drains it; a handshake in that same cycle waits for the next frame
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      full_q <= 1'b0;
      hold_q <= '0;
      last_q <= '0;
    end else if (frame_start && full_q) begin
      full_q <= 1'b0;
      last_q <= hold_q;
    end else if (hs) begin
      full_q <= 1'b1;
      hold_q <= sample_data;
    end
  end

  // Frame FSM with shifter, edge counter, address capture and registered status pulses
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= WAIT_IDLE;
      shift_q      <= '0;
      dout_q       <= 1'b0;
      rcnt_q       <= '0;
      addr_q       <= '0;
      chan_sel_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      underrun_q   <= 1'b0;
      // Address takes effect the cycle after the good-frame pulse
      if (frame_done_q) chan_sel_q <= addr_q;
      case (state_q)
        WAIT_IDLE: begin
          dout_q <= 1'b0;
          if (cs_lvl) state_q <= IDLE;
        end
        IDLE: begin
          dout_q <= 1'b0;
          if (cs_fall) begin
            state_q    <= ACTIVE;
            shift_q    <= frame_word;
            dout_q     <= frame_word[FRAME_LEN-1];
            underrun_q <= ~full_q;
            rcnt_q     <= '0;
            addr_q     <= '0;
          end
        end
        ACTIVE: begin
          // CS_N edge wins over any SCLK edge seen in the same cycle
          if (cs_rise) begin
            state_q <= IDLE;
            dout_q  <= 1'b0;
            if (rcnt_q == RCNT_W'(FRAME_LEN)) frame_done_q <= 1'b1;
            else                              frame_err_q  <= 1'b1;
          end else if (sclk_fall) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
            dout_q  <= shift_q[FRAME_LEN-2];
          end else if (sclk_rise) begin
            if (rcnt_q != RCNT_MAX) rcnt_q <= rcnt_q + 1'b1;
            for (int b = 0; b < ADDR_BITS; b++) begin
              if (rcnt_q == RCNT_W'(ADDR_FIRST_EDGE + b)) addr_q[ADDR_BITS-1-b] <= din_s;
            end
          end
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign ADC_DOUT     = dout_q;
  assign sample_ready = ~full_q;
  assign chan_sel     = chan_sel_q;
  assign frame_done   = frame_done_q;
  assign frame_err    = frame_err_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder acting as the SPI master.
// Master drives SCLK with 5 CLK per phase and latches DOUT as it drives SCLK low.
// Pulse outputs are counted on the falling CLK edge and compared as deltas per scenario.
module tb_adc_spi_responder;

  logic        CLK = 1'b0;
  logic        RSTB;
  logic        ADC_CS_N;
  logic        ADC_SCLK;
  logic        ADC_DIN;
  logic        ADC_DOUT;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [2:0]  chan_sel;
  logic        frame_done;
  logic        frame_err;
  logic        underrun;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_err = 0, n_urun = 0;
  int d0, e0, u0;
  logic [31:0] rx;

  adc_spi_responder dut (
    .CLK          (CLK),
    .RSTB         (RSTB),
    .ADC_CS_N     (ADC_CS_N),
    .ADC_SCLK     (ADC_SCLK),
    .ADC_DIN      (ADC_DIN),
    .ADC_DOUT     (ADC_DOUT),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .chan_sel     (chan_sel),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .underrun     (underrun)
  );

  always #5 CLK = ~CLK;

  // Count every cycle each pulse output is high
  always @(negedge CLK) begin
    if (frame_done) n_done <= n_done + 1;
    if (frame_err)  n_err  <= n_err + 1;
    if (underrun)   n_urun <= n_urun + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    d0 = n_done;
    e0 = n_err;
    u0 = n_urun;
  endtask

  task automatic load(input logic [11:0] d);
    sample_data  = d;
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
  endtask

  // Drop CS_N; optionally offer a sample exactly in the responder's frame-start cycle (3rd CLK edge)
  task automatic cs_low(input logic collide, input logic [11:0] d);
    ADC_CS_N = 1'b0;
    if (collide) begin
      step(2);
      sample_data  = d;
      sample_valid = 1'b1;
      step(1);
      sample_valid = 1'b0;
      step(2);
    end else begin
      step(5);
    end
  endtask

  task automatic clocks(input int n, input logic [15:0] din, output logic [31:0] rxo);
    rxo = '0;
    for (int i = 0; i < n; i++) begin
      rxo      = {rxo[30:0], ADC_DOUT};
      ADC_SCLK = 1'b0;
      ADC_DIN  = (i < 16) ? din[15-i] : 1'b0;
      step(5);
      ADC_SCLK = 1'b1;
      step(5);
    end
  endtask

  task automatic cs_high();
    ADC_CS_N = 1'b1;
    ADC_DIN  = 1'b0;
    step(6);
  endtask

  initial begin
    RSTB = 1'b0; ADC_CS_N = 1'b1; ADC_SCLK = 1'b1; ADC_DIN = 1'b0;
    sample_data = '0; sample_valid = 1'b0;
    step(3);
    chk("rst_dout",  32'(ADC_DOUT), 0);
    chk("rst_ready", 32'(sample_ready), 1);
    chk("rst_chan",  32'(chan_sel), 0);
    chk("rst_done",  32'(frame_done), 0);
    chk("rst_err",   32'(frame_err), 0);
    chk("rst_urun",  32'(underrun), 0);
    RSTB = 1'b1;
    step(5);

    // Standard frame, address 101, with exact status latencies
    load(12'hA5C);
    chk("std_ready_lo", 32'(sample_ready), 0);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h2800, rx);
    ADC_CS_N = 1'b1;
    step(2);
    chk("std_done_2clk", 32'(frame_done), 0);
    step(1);
    chk("std_done_3clk", 32'(frame_done), 1);
    chk("std_chan_3clk", 32'(chan_sel), 0);
    step(1);
    chk("std_chan_4clk", 32'(chan_sel), 3'b101);
    step(4);
    chk("std_rx",    rx & 32'hFFFF, 32'h0A5C);
    chk("std_ndone", 32'(n_done - d0), 1);
    chk("std_nerr",  32'(n_err - e0), 0);
    chk("std_nurun", 32'(n_urun - u0), 0);
    chk("std_ready", 32'(sample_ready), 1);

    // Underrun: one sample, two frames, address 011
    load(12'h123);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h1800, rx);
    cs_high();
    chk("ur1_rx",   rx & 32'hFFFF, 32'h0123);
    chk("ur1_urun", 32'(n_urun - u0), 0);
    chk("ur1_chan", 32'(chan_sel), 3'b011);
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h1800, rx);
    cs_high();
    chk("ur2_rx",   rx & 32'hFFFF, 32'h0123);
    chk("ur2_urun", 32'(n_urun - u0), 1);
    chk("ur_ndone", 32'(n_done - d0), 2);

    // Short frame: 10 SCLK carrying address 111 must not change chan_sel
    load(12'h3C7);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(10, 16'h3800, rx);
    cs_high();
    chk("short_rx",    rx & 32'h3FF, 32'h00F);
    chk("short_nerr",  32'(n_err - e0), 1);
    chk("short_ndone", 32'(n_done - d0), 0);
    chk("short_chan",  32'(chan_sel), 3'b011);
    load(12'h456);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h1800, rx);
    cs_high();
    chk("after_short_rx",    rx & 32'hFFFF, 32'h0456);
    chk("after_short_ndone", 32'(n_done - d0), 1);
    chk("after_short_urun",  32'(n_urun - u0), 0);

    // Long frame: 18 SCLK, trailing bits zero, still an error
    load(12'h789);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(18, 16'h0800, rx);
    cs_high();
    chk("long_rx",    rx & 32'h3FFFF, 32'h01E24);
    chk("long_nerr",  32'(n_err - e0), 1);
    chk("long_ndone", 32'(n_done - d0), 0);
    chk("long_ready", 32'(sample_ready), 1);
    chk("long_chan",  32'(chan_sel), 3'b011);

    // Collision: sample offered in the frame-start cycle with an empty hold
    snap();
    cs_low(1'b1, 12'hABC);
    clocks(16, 16'h1800, rx);
    cs_high();
    chk("coll_rx",    rx & 32'hFFFF, 32'h0789);
    chk("coll_urun",  32'(n_urun - u0), 1);
    chk("coll_ready", 32'(sample_ready), 0);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h1800, rx);
    cs_high();
    chk("coll_next_rx",   rx & 32'hFFFF, 32'h0ABC);
    chk("coll_next_urun", 32'(n_urun - u0), 0);

    // Reset after 7 SCLK with CS_N held low; remainder of the frame is ignored
    load(12'h5A5);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(7, 16'h2800, rx);
    RSTB = 1'b0;
    step(2);
    chk("mrst_dout",  32'(ADC_DOUT), 0);
    chk("mrst_ready", 32'(sample_ready), 1);
    chk("mrst_chan",  32'(chan_sel), 0);
    chk("mrst_urun",  32'(underrun), 0);
    RSTB = 1'b1;
    step(1);
    clocks(9, 16'hFFFF, rx);
    cs_high();
    chk("mrst_tail_rx", rx & 32'h1FF, 32'h000);
    chk("mrst_ndone",   32'(n_done - d0), 0);
    chk("mrst_nerr",    32'(n_err - e0), 0);
    load(12'h321);
    snap();
    cs_low(1'b0, 12'h000);
    clocks(16, 16'h2800, rx);
    cs_high();
    chk("post_rst_rx",    rx & 32'hFFFF, 32'h0321);
    chk("post_rst_ndone", 32'(n_done - d0), 1);
    chk("post_rst_chan",  32'(chan_sel), 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
